// File: rtl/mean_unit_if.sv
// Handshake/data bundle between a vector source, mean_unit and the downstream
// variance stage.
interface mean_unit_if #(
  parameter int unsigned D_MODEL    = 128,
  parameter int unsigned DATA_WIDTH = 24
);
  logic [D_MODEL*DATA_WIDTH-1:0] data_in_flat;
  logic                          start_mean;
  logic                          ds_busy;
  logic signed [DATA_WIDTH-1:0]  mean_out;
  logic                          mean_valid;
  logic                          busy;

  modport master (
    output data_in_flat, start_mean, ds_busy,
    input  mean_out, mean_valid, busy
  );

  modport slave (
    input  data_in_flat, start_mean, ds_busy,
    output mean_out, mean_valid, busy
  );
endinterface

// File: rtl/mean_unit.sv
// Signed vector mean: NUM_PE elements summed per cycle over D_MODEL/NUM_PE rounds.
// Define MEAN_UNIT_ROUND_EN for round-half-up; otherwise the result is a floor.
module mean_unit #(
  parameter int unsigned D_MODEL    = 128,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_PE     = 8
) (
  input logic        clk,
  input logic        rst_n,
  mean_unit_if.slave bus
);
  localparam int unsigned ROUNDS = D_MODEL / NUM_PE;
  localparam int unsigned LOG2_D = $clog2(D_MODEL);
  localparam int unsigned ACC_W  = DATA_WIDTH + LOG2_D + 1;
  localparam int unsigned RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned ROW_W  = NUM_PE * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, OUT} state_t;

  state_t                   state, state_nxt;
  logic [RW-1:0]            round;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_adj;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  round_sum;
  logic signed [DATA_WIDTH-1:0] mean_q;
  logic                     clr_acc, add_acc, load_mean, last_round;

  // The flat input viewed as ROUNDS rows of NUM_PE elements; only the current row is read.
  logic [ROUNDS-1:0][ROW_W-1:0] rows;
  logic [ROW_W-1:0]             row;

  assign rows       = bus.data_in_flat;
  assign row        = rows[round];
  assign last_round = (round == RW'(ROUNDS - 1));

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    logic signed [DATA_WIDTH-1:0] e;
    logic signed [ACC_W-1:0]      ext;
    logic signed [ACC_W-1:0]      s;
    assign e   = row[p*DATA_WIDTH +: DATA_WIDTH];
    assign ext = {{(ACC_W-DATA_WIDTH){e[DATA_WIDTH-1]}}, e};
    if (p == 0) begin : g_first
      assign s = ext;
    end else begin : g_rest
      assign s = g_pe[p-1].s + ext;
    end
  end
  assign round_sum = g_pe[NUM_PE-1].s;

`ifdef MEAN_UNIT_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (LOG2_D - 1));
  assign acc_adj = acc + HALF;
`else
  assign acc_adj = acc;
`endif
  assign shifted = acc_adj >>> LOG2_D;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_acc   = 1'b0;
    add_acc   = 1'b0;
    load_mean = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_mean) begin
          clr_acc   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        add_acc = 1'b1;
        if (last_round) state_nxt = DONE;
      end
      DONE: begin
        if (!bus.ds_busy) begin
          load_mean = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      round  <= '0;
      mean_q <= '0;
    end else begin
      if (clr_acc) begin
        acc   <= '0;
        round <= '0;
      end else if (add_acc) begin
        acc <= acc + round_sum;
        if (!last_round) round <= round + RW'(1);
      end
      if (load_mean) mean_q <= shifted[DATA_WIDTH-1:0];
    end
  end

  // mean_valid is the OUT state itself, so it is exactly one cycle wide.
  assign bus.mean_out   = mean_q;
  assign bus.mean_valid = (state == OUT);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mean_unit.sv
// Self-checking bench for mean_unit: directed table, multi-cycle corner sequences
// and randomized vectors against a floor/round-half-up arithmetic reference.
module tb_mean_unit;
  localparam int unsigned D  = 128;
  localparam int unsigned W  = 24;
  localparam int unsigned PE = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   elems [D];

  mean_unit_if #(.D_MODEL(D), .DATA_WIDTH(W)) bus ();

  mean_unit #(.D_MODEL(D), .DATA_WIDTH(W), .NUM_PE(PE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int kind;      // 0 all ones, 1 ramp i, 2 single -1 at index 5, 3 all most-negative
    int hold;      // ds_busy cycles after DONE is reached
    bit restart;   // re-pulse start_mean at round 7
    bit sio;       // start_mean presented while in OUT
    int expected;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_data();
    logic [D*W-1:0] flat;
    flat = '0;
    for (int i = 0; i < int'(D); i++) flat[i*W +: W] = W'(elems[i]);
    bus.data_in_flat = flat;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < int'(D); i++) begin
      case (kind)
        0:       elems[i] = 1;
        1:       elems[i] = i;
        2:       elems[i] = (i == 5) ? -1 : 0;
        default: elems[i] = -8388608;
      endcase
    end
  endtask

  // Reference: exact integer sum, then floor division by D (with +D/2 when rounding).
  function automatic int model_mean();
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < int'(D); i++) s += longint'(elems[i]);
`ifdef MEAN_UNIT_ROUND_EN
    s += longint'(D / 2);
`endif
    q = s / longint'(D);
    if ((s % longint'(D) != 0) && (s < 0)) q -= 1;
    return int'(q);
  endfunction

  task automatic run_vec(input string tag, input int exp, input int hold,
                         input bit restart, input bit sio);
    int   cycles;
    bit   busy_ok;
    bit   hold_ok;
    logic signed [W-1:0] prev;
    prev = bus.mean_out;
    @(negedge clk);
    bus.start_mean = 1'b1;
    if (hold > 0) bus.ds_busy = 1'b1;
    @(negedge clk);
    bus.start_mean = 1'b0;
    cycles  = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!bus.mean_valid && cycles < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.mean_out !== prev) hold_ok = 1'b0;
      if (hold > 0 && cycles == 16 + hold) bus.ds_busy = 1'b0;
      bus.start_mean = restart && (cycles == 7);
      @(negedge clk);
      cycles++;
    end
    bus.start_mean = 1'b0;
    bus.ds_busy    = 1'b0;
    chk({tag, " latency"}, cycles, 17 + hold);
    chk({tag, " mean_out"}, longint'(bus.mean_out), exp);
    chk({tag, " busy during compute"}, busy_ok, 1);
    chk({tag, " mean_out held"}, hold_ok, 1);
    if (sio) bus.start_mean = 1'b1;
    @(negedge clk);
    bus.start_mean = 1'b0;
    chk({tag, " valid one cycle"}, bus.mean_valid, 0);
    chk({tag, " idle after out"}, bus.busy, 0);
    chk({tag, " mean_out after out"}, longint'(bus.mean_out), exp);
  endtask

  vec_t tbl [6];

  initial begin
    int seen;
    int v;
    int hold;
    total = 0;
    bad   = 0;

`ifdef MEAN_UNIT_ROUND_EN
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1};
    tbl[1] = '{1, 0, 1'b0, 1'b0, 64};
    tbl[2] = '{2, 0, 1'b0, 1'b0, 0};
    tbl[3] = '{3, 0, 1'b0, 1'b0, -8388608};
    tbl[4] = '{1, 5, 1'b0, 1'b0, 64};
    tbl[5] = '{0, 0, 1'b1, 1'b1, 1};
`else
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1};
    tbl[1] = '{1, 0, 1'b0, 1'b0, 63};
    tbl[2] = '{2, 0, 1'b0, 1'b0, -1};
    tbl[3] = '{3, 0, 1'b0, 1'b0, -8388608};
    tbl[4] = '{1, 5, 1'b0, 1'b0, 63};
    tbl[5] = '{0, 0, 1'b1, 1'b1, 1};
`endif

    rst_n            = 1'b0;
    bus.start_mean   = 1'b0;
    bus.ds_busy      = 1'b0;
    bus.data_in_flat = '0;
    repeat (3) @(negedge clk);
    chk("reset mean_out", longint'(bus.mean_out), 0);
    chk("reset mean_valid", bus.mean_valid, 0);
    chk("reset busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].kind);
      apply_data();
      run_vec($sformatf("vec%0d", t), tbl[t].expected, tbl[t].hold,
              tbl[t].restart, tbl[t].sio);
    end

    // Reset in the middle of accumulation: no pulse, outputs cleared.
    fill(1);
    apply_data();
    @(negedge clk);
    bus.start_mean = 1'b1;
    @(negedge clk);
    bus.start_mean = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset mean_out", longint'(bus.mean_out), 0);
    chk("midreset mean_valid", bus.mean_valid, 0);
    chk("midreset busy", bus.busy, 0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.mean_valid) seen++;
    end
    chk("midreset no pulse", seen, 0);
    fill(1);
    apply_data();
    run_vec("after reset", model_mean(), 0, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < int'(D); i++) begin
        if (r % 2 == 0) begin
          v = int'($urandom_range(0, 16777215));
          elems[i] = (v >= 8388608) ? v - 16777216 : v;
        end else begin
          elems[i] = int'($urandom_range(0, 400)) - 200;
        end
      end
      hold = (r % 4 == 3) ? int'($urandom_range(1, 4)) : 0;
      apply_data();
      run_vec($sformatf("rand%0d", r), model_mean(), hold, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mean_unit.md
MEAN_UNIT -- requirements
Module: mean_unit

Interface
REQ-001 SHALL have parameter D_MODEL, default 128, meaning the element count per vector; it SHALL be a power of two and a multiple of NUM_PE.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, meaning the signed element and mean width.
REQ-003 SHALL have parameter NUM_PE, default 8, meaning the parallel adders per round; ROUNDS = D_MODEL/NUM_PE (16 at defaults).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port data_in_flat  input  D_MODEL*DATA_WIDTH  signed elements, with element i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-007 SHALL have port start_mean  input  1  a request to begin a computation.
REQ-008 SHALL have port ds_busy  input  1  high while the downstream variance consumer cannot accept a start.
REQ-009 SHALL have port mean_out  output  DATA_WIDTH  the signed mean result.
REQ-010 SHALL have port mean_valid  output  1  a one-cycle pulse that drives the downstream start_variance input.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, ACCUM, DONE and OUT.
REQ-013 In IDLE, start_mean=1 SHALL transition the block to ACCUM, clear the accumulator and set round to 0.
REQ-014 start_mean SHALL be ignored in every state other than IDLE.
REQ-015 In each ACCUM cycle, the block SHALL add the elements round*NUM_PE through round*NUM_PE+NUM_PE-1, sign-extended, into the accumulator.
REQ-016 When round reaches ROUNDS-1, the block SHALL perform that round's addition and transition to DONE; otherwise it SHALL increment round.
REQ-017 In DONE with ds_busy=0, the block SHALL register mean_out, pulse mean_valid for one cycle and transition to IDLE.
REQ-018 In DONE with ds_busy=1, the block SHALL stay in DONE, with mean_valid=0 and the accumulator held.
REQ-019 Latency: with start_mean sampled at edge k and ds_busy=0, mean_valid SHALL be high for exactly the cycle following edge k+ROUNDS+1 (17 cycles at defaults).
REQ-020 The accumulator SHALL be signed, DATA_WIDTH+log2(D_MODEL)+1 bits wide, and SHALL never overflow.
REQ-021 mean_out SHALL equal the accumulator arithmetically shifted right by log2(D_MODEL), truncated to DATA_WIDTH (floor toward minus infinity).
REQ-022 mean_out SHALL hold its value between completions.
REQ-023 The source SHALL hold data_in_flat stable while busy=1; the block SHALL not latch the full vector.
REQ-024 A start_mean presented in the same cycle that OUT returns to IDLE SHALL be ignored; a start is accepted only when sampled in IDLE.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set state IDLE, round 0, accumulator 0, mean_out 0, mean_valid 0 and busy 0.
REQ-026 A reset asserted mid-ACCUM or mid-DONE SHALL abort the computation with no mean_valid pulse; the next accepted start SHALL compute from a cleared accumulator.

Configuration
REQ-027 The macro MEAN_UNIT_ROUND_EN SHALL select the rounding mode.
REQ-028 With MEAN_UNIT_ROUND_EN defined, the block SHALL add 2^(log2(D_MODEL)-1) to the accumulator before the shift, giving round-half-up.
REQ-029 Without MEAN_UNIT_ROUND_EN, the block SHALL use the plain floor shift of REQ-021.

Verification
REQ-030 All 128 elements = 1, start at edge 0, ds_busy=0 -> mean_out=1, with mean_valid high for one cycle, 17 cycles after the start edge.
REQ-031 Element i = i (0..127) -> sum 8128; mean_out=63 without the macro, 64 with it.
REQ-032 127 elements = 0 and element 5 = -1 -> mean_out=-1 (0xFFFFFF) without the macro, 0 with it; all elements = -8388608 -> mean_out=-8388608.
REQ-033 ds_busy held high for 5 cycles after DONE is reached -> mean_valid delayed exactly 5 cycles, mean_out value unchanged, busy=1 throughout.
REQ-034 start_mean re-pulsed at round 7 -> ignored and no change in latency; rst_n low for 1 cycle at round 10 -> no mean_valid, all outputs 0; a fresh start then yields the correct result.
